// File: rtl/regfile_gazump_bypass.sv
// regfile_gazump_bypass: resolves per-read-port operands from gazump match
// vectors (write-port bypass or regfile data) and buffers each operand bundle
// in a 3-entry output FIFO with valid/ready handshake.
module regfile_gazump_bypass #(
    parameter int DATA_WIDTH = 16,
    parameter int NREAD      = 9,
    parameter int NWRITE     = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NREAD*(NWRITE+1)-1:0]    read_match,
    input  logic [NWRITE*DATA_WIDTH-1:0]   write_data,
    input  logic [NREAD*DATA_WIDTH-1:0]    rf_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NREAD*DATA_WIDTH-1:0]    out_data,
    output logic                           match_err,
    output logic [15:0]                    byp_count
);

    localparam int MW = NWRITE + 1;
    localparam int BW = NREAD * DATA_WIDTH;

    logic                                accept;
    logic [NREAD-1:0][DATA_WIDTH-1:0]    byp_d;
    logic [NREAD-1:0]                    use_rf_d;
    logic                                any_hit;
    logic                                any_illegal;

    logic                                s1_valid;
    logic [NREAD-1:0][DATA_WIDTH-1:0]    s1_byp;
    logic [NREAD-1:0]                    s1_use_rf;

    logic [BW-1:0]                       operand;

    logic [2:0][BW-1:0]                  mem;
    logic [1:0]                          wr_ptr;
    logic [1:0]                          rd_ptr;
    logic [1:0]                          count;
    logic                                push;
    logic                                pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Space for the in-flight stage-1 bundle is reserved before accepting.
    assign in_ready  = ({1'b0, count} + {2'b00, s1_valid}) <= 3'd2;
    assign accept    = in_valid & in_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = s1_valid;
    assign pop       = out_valid & out_ready;

    // Per-port priority select of the lowest hitting write port, plus legality flags.
    always_comb begin
        logic [NWRITE-1:0] hits;
        logic              found;
        byp_d       = '0;
        use_rf_d    = '0;
        any_hit     = 1'b0;
        any_illegal = 1'b0;
        hits        = '0;
        found       = 1'b0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            hits  = read_match[k*MW +: NWRITE];
            found = 1'b0;
            for (int unsigned j = 0; j < NWRITE; j++) begin
                if (!found && hits[j]) begin
                    byp_d[k] = write_data[j*DATA_WIDTH +: DATA_WIDTH];
                    found    = 1'b1;
                end
            end
            use_rf_d[k] = ~|hits;
            if (|hits) begin
                any_hit = 1'b1;
            end
            if (((hits & (hits - 1'b1)) != '0) ||
                (read_match[k*MW +: MW] == '0) ||
                (read_match[k*MW + NWRITE] && |hits)) begin
                any_illegal = 1'b1;
            end
        end
    end

    // Stage 1 register: captured bypass data and regfile-select per port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_byp    <= '0;
            s1_use_rf <= '0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_byp    <= byp_d;
            s1_use_rf <= use_rf_d;
        end else begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2 operand mux: regfile data arrives one cycle after the match.
    always_comb begin
        operand = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            operand[k*DATA_WIDTH +: DATA_WIDTH] = s1_use_rf[k] ?
                rf_data[k*DATA_WIDTH +: DATA_WIDTH] : s1_byp[k];
        end
    end

    // Output FIFO storage and pointers; push never overflows thanks to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= operand;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky illegal-match flag and saturating bypassed-bundle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_err <= 1'b0;
            byp_count <= '0;
        end else if (accept) begin
            if (any_illegal) begin
                match_err <= 1'b1;
            end
            if (any_hit && (byp_count != 16'hFFFF)) begin
                byp_count <= byp_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_gazump_bypass.sv
// Randomized self-checking bench for regfile_gazump_bypass with a scoreboard
// reference model computed from the match-vector rules.
module tb_regfile_gazump_bypass;

    localparam int DW = 16;
    localparam int NR = 9;
    localparam int NW = 10;
    localparam int MW = NW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NR*MW-1:0]  read_match;
    logic [NW*DW-1:0]  write_data;
    logic [NR*DW-1:0]  rf_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NR*DW-1:0]  out_data;
    logic              match_err;
    logic [15:0]       byp_count;

    always #5 clk = ~clk;

    regfile_gazump_bypass #(.DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .read_match (read_match),
        .write_data (write_data),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .match_err  (match_err),
        .byp_count  (byp_count)
    );

    typedef struct {
        logic [NR*DW-1:0] data;
        int               cyc;
    } exp_t;

    exp_t             q[$];
    logic [MW-1:0]    bm [NR];
    logic [DW-1:0]    wd [NW];
    logic [DW-1:0]    rfs [NR];
    logic [NR*DW-1:0] rf_next;
    bit               rf_pending;
    int               cyc;
    int               checks;
    int               failures;
    int               accs;
    int               pops;
    logic [15:0]      m_byp;
    bit               m_err;

    always_comb begin
        read_match = '0;
        write_data = '0;
        for (int k = 0; k < NR; k++) read_match[k*MW +: MW] = bm[k];
        for (int j = 0; j < NW; j++) write_data[j*DW +: DW] = wd[j];
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Legal random bundle: each port either reads the regfile or hits one write port.
    task automatic rand_bundle();
        int r;
        for (int k = 0; k < NR; k++) begin
            r = $urandom_range(0, NW);
            bm[k] = (r == NW) ? 11'h400 : (11'h001 << r);
            rfs[k] = DW'($urandom);
        end
        for (int j = 0; j < NW; j++) wd[j] = DW'($urandom);
    endtask

    // Called at posedge+1; checks at mid-cycle, updates the model, advances one clock.
    task automatic cycle();
        exp_t             e;
        logic [NR*DW-1:0] d;
        logic [NW-1:0]    hit;
        bit               anyb;
        bit               err;
        bit               found;
        #4;
        check("out_valid", out_valid, (q.size() > 0 && q[0].cyc <= cyc - 2));
        check("in_ready", in_ready, (q.size() <= 2));
        check("byp_count", byp_count, m_byp);
        check("match_err", match_err, m_err);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("pop_when_empty", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.data);
                pops++;
            end
        end
        if (in_valid && in_ready) begin
            d = '0; anyb = 0; err = 0;
            for (int k = 0; k < NR; k++) begin
                hit = bm[k][NW-1:0];
                if (hit != 0) begin
                    anyb = 1; found = 0;
                    for (int j = 0; j < NW; j++)
                        if (!found && hit[j]) begin d[k*DW +: DW] = wd[j]; found = 1; end
                end else begin
                    d[k*DW +: DW] = rfs[k];
                end
                if ($countones(hit) > 1 || bm[k] == 0 || (bm[k][NW] && hit != 0)) err = 1;
            end
            e.data = d; e.cyc = cyc;
            q.push_back(e);
            accs++;
            if (anyb && m_byp != 16'hFFFF) m_byp++;
            if (err) m_err = 1;
            rf_pending = 1;
            for (int k = 0; k < NR; k++) rf_next[k*DW +: DW] = rfs[k];
        end else begin
            rf_pending = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rf_pending) rf_data = rf_next;
        else for (int k = 0; k < NR; k++) rf_data[k*DW +: DW] = DW'($urandom);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_byp_count"}, byp_count, 0);
        check({tag, "_match_err"}, match_err, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; called at posedge+1.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_async");
        q.delete(); m_byp = '0; m_err = 0; rf_pending = 0;
        @(posedge clk);
        #1 reset_checks("rst_edge");
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        int a0, p0;
        checks = 0; failures = 0; cyc = 0; accs = 0; pops = 0;
        m_byp = '0; m_err = 0; rf_pending = 0;
        rand_bundle();
        #1 reset_checks("rst_init");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed bypass / regfile select.
        rand_bundle();
        bm[0] = 11'h004; wd[2] = 16'hAAAA;
        bm[1] = 11'h400; rfs[1] = 16'h1234;
        in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        cycle();
        check("byp_valid_t2", out_valid, 1);
        check("byp_port0", out_data[15:0], 16'hAAAA);
        check("rf_port1", out_data[31:16], 16'h1234);
        cycle(); cycle();

        // Multi-hit takes lowest index and sets the sticky error.
        rand_bundle();
        bm[0] = 11'h00A; wd[1] = 16'h0011; wd[3] = 16'h0033;
        in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        check("multihit_port0", out_data[15:0], 16'h0011);
        check("multihit_err", match_err, 1);
        for (int i = 0; i < 4; i++) cycle();
        check("err_sticky", match_err, 1);

        // Stall: continuous in_valid with out_ready low.
        out_ready = 0; in_valid = 1;
        a0 = accs;
        for (int i = 0; i < 8; i++) begin rand_bundle(); cycle(); end
        check("stall_accepts", accs - a0, 3);
        check("stall_in_ready", in_ready, 0);
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) cycle();
        check("drain_empty", q.size(), 0);

        // Reset with two bundles held in the FIFO.
        out_ready = 0; in_valid = 1;
        rand_bundle(); cycle();
        rand_bundle(); cycle();
        in_valid = 0;
        cycle(); cycle();
        check("pre_rst_valid", out_valid, 1);
        async_reset();
        for (int i = 0; i < 3; i++) cycle();

        // All-zero match vector reads the regfile and flags an error.
        out_ready = 1;
        rand_bundle();
        bm[0] = 11'h000; rfs[0] = 16'h5A5A;
        in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        check("zero_port0", out_data[15:0], 16'h5A5A);
        check("zero_err", match_err, 1);
        cycle(); cycle();

        // Streaming with random out_ready toggling first, then back-to-back.
        for (int i = 0; i < 40; i++) begin
            rand_bundle();
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            cycle();
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) cycle();
        a0 = accs; p0 = pops;
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin rand_bundle(); cycle(); end
        in_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("stream_accepts", accs - a0, 100);
        check("stream_pops", pops - p0, 100);
        check("stream_byp_count", byp_count, m_byp);

        // Saturation of the bypass counter.
        in_valid = 1;
        for (int i = 0; i < 65540; i++) begin
            rand_bundle();
            bm[0] = 11'h001;
            cycle();
        end
        in_valid = 0;
        cycle(); cycle(); cycle();
        check("byp_saturated", byp_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
